// File: rtl/tod_pps_gen.sv
// tod_pps_gen: 1PPS generator and one-shot time-of-day trigger driven by the
// RTC ns/sec outputs. Everything runs on the RTC clock; all comparisons use a
// registered copy of the input time so both FSMs see the same instant.
module tod_pps_gen #(
  parameter int unsigned NS_PER_SEC    = 1_000_000_000,
  parameter int unsigned PPS_WIDTH_DEF = 500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] time_ns,
  input  logic [47:0] time_sec,
  input  logic        pps_en,
  input  logic [31:0] pps_width,
  input  logic        trig_arm,
  input  logic        trig_disarm,
  input  logic [47:0] trig_sec,
  input  logic [31:0] trig_ns,
  output logic        pps_out,
  output logic [31:0] pps_cnt,
  output logic [47:0] pps_ts_sec,
  output logic        trig_armed,
  output logic        trig_out,
  output logic        trig_late,
  output logic        trig_err
);

  localparam logic [31:0] NS_LIM = 32'(NS_PER_SEC);
  localparam logic [31:0] DEF_W  = 32'(PPS_WIDTH_DEF);

  typedef enum logic {PPS_IDLE, PPS_HIGH} pps_state_t;
  typedef enum logic {TRG_DISARMED, TRG_ARMED} trg_state_t;

  logic [31:0] t_ns;
  logic [47:0] t_sec;
  logic [47:0] sec_prev;
  logic        loaded;
  logic        valid;
  logic        boundary;
  logic [79:0] cur;
  logic [79:0] new_tgt;
  logic [79:0] tgt;
  logic [31:0] width_eff;

  pps_state_t pps_st, pps_nxt;
  logic       pps_rise;
  trg_state_t trg_st, trg_nxt;
  logic       tgt_ld, fire, late, err;

  // Stage-1 time capture. valid trails the first load by one edge so the
  // jump from the reset value to the first real seconds value is not taken
  // as a boundary; only the next seconds change is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_ns     <= '0;
      t_sec    <= '0;
      sec_prev <= '0;
      loaded   <= 1'b0;
      valid    <= 1'b0;
    end else begin
      t_ns     <= time_ns;
      t_sec    <= time_sec;
      sec_prev <= t_sec;
      loaded   <= 1'b1;
      valid    <= loaded;
    end
  end

  assign boundary  = valid && (t_sec != sec_prev);
  assign cur       = {t_sec, t_ns};
  assign new_tgt   = {trig_sec, trig_ns};
  assign width_eff = (pps_width < NS_LIM) ? pps_width : DEF_W;

  // PPS next state: a boundary (re)starts the pulse, width or disable ends it.
  always_comb begin
    pps_nxt  = pps_st;
    pps_rise = 1'b0;
    case (pps_st)
      PPS_IDLE: begin
        if (boundary && pps_en) begin
          pps_nxt  = PPS_HIGH;
          pps_rise = 1'b1;
        end
      end
      PPS_HIGH: begin
        if (!pps_en)             pps_nxt  = PPS_IDLE;
        else if (boundary)       pps_rise = 1'b1;
        else if (t_ns >= width_eff) pps_nxt = PPS_IDLE;
      end
      default: pps_nxt = PPS_IDLE;
    endcase
  end

  // PPS state, edge counter and seconds timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_st     <= PPS_IDLE;
      pps_cnt    <= '0;
      pps_ts_sec <= '0;
    end else begin
      pps_st <= pps_nxt;
      if (pps_rise) begin
        pps_cnt    <= pps_cnt + 32'd1;
        pps_ts_sec <= t_sec;
      end
    end
  end

  assign pps_out = (pps_st == PPS_HIGH);

  // Trigger next state. Priority: disarm, then arm (re-evaluated even when
  // already armed), then firing on reaching the target.
  always_comb begin
    trg_nxt = trg_st;
    tgt_ld  = 1'b0;
    fire    = 1'b0;
    late    = 1'b0;
    err     = 1'b0;
    if (trig_disarm) begin
      trg_nxt = TRG_DISARMED;
    end else if (trig_arm) begin
      if (trig_ns >= NS_LIM) begin
        err     = 1'b1;
        trg_nxt = TRG_DISARMED;
      end else if (new_tgt <= cur) begin
        late    = 1'b1;
        trg_nxt = TRG_DISARMED;
      end else begin
        tgt_ld  = 1'b1;
        trg_nxt = TRG_ARMED;
      end
    end else if ((trg_st == TRG_ARMED) && (cur >= tgt)) begin
      fire    = 1'b1;
      trg_nxt = TRG_DISARMED;
    end
  end

  // Trigger state, captured target and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trg_st    <= TRG_DISARMED;
      tgt       <= '0;
      trig_out  <= 1'b0;
      trig_late <= 1'b0;
      trig_err  <= 1'b0;
    end else begin
      trg_st    <= trg_nxt;
      trig_out  <= fire;
      trig_late <= late;
      trig_err  <= err;
      if (tgt_ld) tgt <= new_tgt;
    end
  end

  assign trig_armed = (trg_st == TRG_ARMED);

endmodule

// File: tb/tb_tod_pps_gen.sv
// tb_tod_pps_gen: directed scenarios followed by randomized time/trigger
// traffic, every cycle compared against a behavioural model of the block.
module tb_tod_pps_gen;
  localparam logic [31:0] NS  = 32'd1_000_000_000;
  localparam logic [31:0] DEF = 32'd500_000_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] time_ns, pps_width, trig_ns;
  logic [47:0] time_sec, trig_sec;
  logic        pps_en, trig_arm, trig_disarm;
  logic        pps_out, trig_armed, trig_out, trig_late, trig_err;
  logic [31:0] pps_cnt;
  logic [47:0] pps_ts_sec;

  int checks = 0;
  int errors = 0;

  // model state
  logic [79:0] m_t, m_tgt;
  logic [47:0] m_prev_sec, m_ts;
  logic [31:0] m_cnt;
  int          m_loads;
  logic        m_pps, m_armed, m_out, m_late, m_err;

  tod_pps_gen dut (
    .clk(clk), .rst_n(rst_n), .time_ns(time_ns), .time_sec(time_sec),
    .pps_en(pps_en), .pps_width(pps_width), .trig_arm(trig_arm),
    .trig_disarm(trig_disarm), .trig_sec(trig_sec), .trig_ns(trig_ns),
    .pps_out(pps_out), .pps_cnt(pps_cnt), .pps_ts_sec(pps_ts_sec),
    .trig_armed(trig_armed), .trig_out(trig_out), .trig_late(trig_late),
    .trig_err(trig_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = '0; m_tgt = '0; m_prev_sec = '0; m_ts = '0; m_cnt = '0; m_loads = 0;
    m_pps = 1'b0; m_armed = 1'b0; m_out = 1'b0; m_late = 1'b0; m_err = 1'b0;
  endtask

  // One rising edge of the reference: the time seen by both FSMs is the
  // input applied one edge earlier; the PPS level is a formula over it.
  task automatic model_edge();
    logic [79:0] want;
    logic [47:0] s1;
    logic [31:0] w;
    logic        bnd;
    want = {trig_sec, trig_ns};
    s1   = m_t[79:32];
    bnd  = (m_loads >= 2) && (s1 != m_prev_sec);
    w    = (pps_width < NS) ? pps_width : DEF;
    if (pps_en && bnd) begin
      m_cnt = m_cnt + 32'd1;
      m_ts  = s1;
    end
    m_pps = pps_en && (bnd || (m_pps && (m_t[31:0] < w)));
    m_out = 1'b0; m_late = 1'b0; m_err = 1'b0;
    if (trig_disarm) m_armed = 1'b0;
    else if (trig_arm) begin
      if (trig_ns >= NS)     begin m_err = 1'b1;  m_armed = 1'b0; end
      else if (want <= m_t)  begin m_late = 1'b1; m_armed = 1'b0; end
      else                   begin m_armed = 1'b1; m_tgt = want; end
    end else if (m_armed && (m_t >= m_tgt)) begin
      m_out = 1'b1; m_armed = 1'b0;
    end
    m_prev_sec = s1;
    m_t = {time_sec, time_ns};
    if (m_loads < 2) m_loads++;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pps_out"},    pps_out,    m_pps);
    chk({tag, ".pps_cnt"},    pps_cnt,    m_cnt);
    chk({tag, ".pps_ts_sec"}, pps_ts_sec, m_ts);
    chk({tag, ".trig_armed"}, trig_armed, m_armed);
    chk({tag, ".trig_out"},   trig_out,   m_out);
    chk({tag, ".trig_late"},  trig_late,  m_late);
    chk({tag, ".trig_err"},   trig_err,   m_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all(tag);
    trig_arm    = 1'b0;
    trig_disarm = 1'b0;
  endtask

  task automatic set_time(input logic [47:0] s, input logic [31:0] n);
    time_sec = s;
    time_ns  = n;
  endtask

  task automatic arm(input logic [47:0] s, input logic [31:0] n);
    trig_sec = s;
    trig_ns  = n;
    trig_arm = 1'b1;
  endtask

  initial begin
    logic [47:0] rs;
    logic [31:0] rn;
    rst_n = 1'b0; pps_en = 1'b0; pps_width = 32'd100;
    trig_arm = 1'b0; trig_disarm = 1'b0; trig_sec = '0; trig_ns = '0;
    set_time(48'd5, 32'd999_999_990);
    model_reset();
    #2;
    chk("reset.pps_out", pps_out, 1'b0);
    chk("reset.pps_cnt", pps_cnt, 32'd0);
    tick("reset");
    tick("reset");
    rst_n = 1'b1;

    // PPS basic: the reset-to-5 load is not a boundary; 5->6 is.
    pps_en = 1'b1;
    repeat (3) tick("settle");
    chk("pps_basic.no_early", pps_out, 1'b0);
    set_time(48'd6, 32'd0);
    tick("pps_basic");
    chk("pps_basic.edge1_low", pps_out, 1'b0);
    tick("pps_basic");
    chk("pps_basic.edge2_high", pps_out, 1'b1);
    for (int n = 8; n <= 120; n += 8) begin
      set_time(48'd6, 32'(n));
      tick("pps_basic_run");
    end
    chk("pps_basic.fell", pps_out, 1'b0);
    chk("pps_basic.cnt", pps_cnt, 32'd1);
    chk("pps_basic.ts", pps_ts_sec, 48'd6);

    // Out-of-range width falls back to the default width.
    pps_width = 32'd2_000_000_000;
    set_time(48'd7, 32'd0);
    tick("clip"); tick("clip");
    chk("clip.high", pps_out, 1'b1);
    set_time(48'd7, 32'd499_999_999);
    tick("clip"); tick("clip");
    chk("clip.still_high", pps_out, 1'b1);
    set_time(48'd7, 32'd500_000_000);
    tick("clip");
    chk("clip.last_high", pps_out, 1'b1);
    tick("clip");
    chk("clip.low", pps_out, 1'b0);

    // Zero width: one cycle even with time frozen.
    pps_width = 32'd0;
    set_time(48'd8, 32'd0);
    tick("w0"); tick("w0");
    chk("w0.high", pps_out, 1'b1);
    tick("w0");
    chk("w0.low", pps_out, 1'b0);

    // Back-to-back seconds with wide pulse restart without a low cycle.
    pps_width = 32'd999_999_999;
    set_time(48'd9, 32'd0);
    tick("b2b"); tick("b2b");
    set_time(48'd10, 32'd0);
    tick("b2b");
    chk("b2b.hold1", pps_out, 1'b1);
    tick("b2b");
    chk("b2b.hold2", pps_out, 1'b1);
    chk("b2b.cnt", pps_cnt, 32'd5);
    chk("b2b.ts", pps_ts_sec, 48'd10);

    // Trigger fire at (10,400).
    pps_en = 1'b0;
    tick("trg");
    arm(48'd10, 32'd400);
    tick("trg_arm");
    chk("trg.armed", trig_armed, 1'b1);
    for (int n = 100; n <= 400; n += 100) begin
      set_time(48'd10, 32'(n));
      tick("trg_run");
      chk("trg.not_yet", trig_out, 1'b0);
    end
    tick("trg_fire");
    chk("trg.fire", trig_out, 1'b1);
    chk("trg.disarmed", trig_armed, 1'b0);
    tick("trg_after");
    chk("trg.one_cycle", trig_out, 1'b0);

    // Late and error.
    set_time(48'd10, 32'd0);
    tick("late"); tick("late");
    arm(48'd9, 32'd5);
    tick("late");
    chk("late.pulse", trig_late, 1'b1);
    chk("late.armed", trig_armed, 1'b0);
    arm(48'd20, 32'd1_000_000_000);
    tick("err");
    chk("err.pulse", trig_err, 1'b1);
    chk("err.late_clear", trig_late, 1'b0);

    // Arm and disarm together: disarm wins.
    arm(48'd20, 32'd0);
    trig_disarm = 1'b1;
    tick("armdis");
    chk("armdis.armed", trig_armed, 1'b0);

    // Disarm in the cycle the target is reached.
    set_time(48'd10, 32'd450);
    tick("dis_tgt"); tick("dis_tgt");
    arm(48'd10, 32'd500);
    tick("dis_tgt");
    set_time(48'd10, 32'd500);
    tick("dis_tgt");
    trig_disarm = 1'b1;
    tick("dis_tgt");
    chk("dis_tgt.no_out", trig_out, 1'b0);
    chk("dis_tgt.armed", trig_armed, 1'b0);

    // Backward load while armed does not fire.
    arm(48'd11, 32'd0);
    tick("back");
    set_time(48'd3, 32'd0);
    tick("back"); tick("back");
    chk("back.no_out", trig_out, 1'b0);
    chk("back.armed", trig_armed, 1'b1);
    set_time(48'd11, 32'd0);
    tick("back"); tick("back");
    chk("back.fire", trig_out, 1'b1);

    // Reset mid-pulse and mid-armed.
    pps_en = 1'b1; pps_width = 32'd100;
    set_time(48'd12, 32'd0);
    tick("rst"); tick("rst");
    arm(48'd50, 32'd0);
    tick("rst");
    chk("rst.pre_pps", pps_out, 1'b1);
    chk("rst.pre_armed", trig_armed, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    chk("rst.pps_out", pps_out, 1'b0);
    chk("rst.armed", trig_armed, 1'b0);
    tick("rst_hold"); tick("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("rst_rel");
      chk("rst_rel.no_pulse", pps_out, 1'b0);
    end
    set_time(48'd60, 32'd0);
    tick("rst_rel"); tick("rst_rel");
    chk("rst_rel.pulse", pps_out, 1'b1);
    chk("rst_rel.cnt", pps_cnt, 32'd1);
    chk("rst_rel.no_trig", trig_out, 1'b0);

    // Randomized traffic against the model.
    rs = 48'd100; rn = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        rs = 48'($urandom_range(0, 200));
        rn = $urandom_range(0, 999_999_999);
      end else begin
        rn = rn + $urandom_range(1, 300_000_000);
        if (rn >= NS) begin rn = rn - NS; rs = rs + 48'd1; end
      end
      set_time(rs, rn);
      if ($urandom_range(0, 29) == 0) pps_en = ~pps_en;
      case ($urandom_range(0, 39))
        0: pps_width = 32'd0;
        1: pps_width = $urandom_range(0, 999_999_999);
        2: pps_width = 32'd3_000_000_000;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0)
        arm(rs + 48'($urandom_range(0, 2)) - 48'd1,
            ($urandom_range(0, 7) == 0) ? NS + $urandom_range(0, 5)
                                       : $urandom_range(0, 999_999_999));
      if ($urandom_range(0, 19) == 0) trig_disarm = 1'b1;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tod_pps_gen.md
TOD_PPS_GEN -- requirements
Module: tod_pps_gen

Block: downstream consumer of the RTC PTP time outputs (ns/sec). It generates a 1PPS output and a one-shot time-of-day trigger in the RTC clock domain.

Interface
REQ-001 The block SHALL have parameter NS_PER_SEC, default 1_000_000_000, giving the ns rollover value of time_ns.
REQ-002 The block SHALL have parameter PPS_WIDTH_DEF, default 500_000_000, giving the substitute width used when pps_width is out of range.
REQ-003 clk  in  1  RTC clock; all logic is on rising edge; one clock only.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 time_ns  in  32  RTC nanoseconds, 0..NS_PER_SEC-1.
REQ-006 time_sec  in  48  RTC seconds.
REQ-007 pps_en  in  1  level; enables PPS generation.
REQ-008 pps_width  in  32  PPS high time in ns.
REQ-009 trig_arm  in  1  single-cycle pulse; captures trig_sec/trig_ns.
REQ-010 trig_disarm  in  1  single-cycle pulse; cancels a pending trigger.
REQ-011 trig_sec  in  48  target seconds.
REQ-012 trig_ns  in  32  target nanoseconds.
REQ-013 pps_out  out  1  PPS pulse, registered.
REQ-014 pps_cnt  out  32  count of PPS rising edges.
REQ-015 pps_ts_sec  out  48  time_sec value latched at the last PPS rise.
REQ-016 trig_armed  out  1  high while a trigger is pending.
REQ-017 trig_out  out  1  single-cycle pulse when the target time is reached.
REQ-018 trig_late  out  1  single-cycle pulse when an armed target is already in the past.
REQ-019 trig_err  out  1  single-cycle pulse when trig_ns >= NS_PER_SEC at arm.

Function
REQ-020 Input registration: time_ns and time_sec SHALL be registered (stage 1) before any comparison; sec_prev holds the previous stage-1 seconds value.
REQ-021 Boundary detection: boundary = (stage-1 sec != sec_prev) AND valid.
  - valid is cleared by reset and set after the first stage-1 load, so no boundary is detected on the first cycle after reset.
  - Any seconds change, including a forward or backward time load, is a boundary.
REQ-022 Effective width: w = pps_width when pps_width < NS_PER_SEC, else PPS_WIDTH_DEF.
REQ-023 PPS FSM IDLE: on boundary with pps_en=1, go to HIGH.
  - In the same edge, pps_out=1, pps_cnt+1, and pps_ts_sec = stage-1 sec.
REQ-024 PPS FSM HIGH: go to IDLE with pps_out=0 when stage-1 ns >= w or pps_en=0.
  - A boundary while in HIGH restarts the pulse: pps_out stays 1, pps_cnt+1, pps_ts_sec is updated.
REQ-025 PPS latency: pps_out SHALL rise exactly 2 clk edges after the time_sec input changes.
  - Minimum pulse is 1 cycle (w=0).
REQ-026 pps_cnt SHALL wrap from 0xFFFF_FFFF to 0.
REQ-027 Comparison rule: comparisons SHALL be unsigned on the 80-bit value {sec,ns}, always against stage-1 time.
REQ-028 Trigger FSM DISARMED: on trig_arm, capture the target.
  - If trig_ns >= NS_PER_SEC: pulse trig_err and stay DISARMED.
  - Else if target <= current time: pulse trig_late and stay DISARMED.
  - Else go to ARMED with trig_armed=1.
REQ-029 Trigger FSM ARMED: when current >= target, pulse trig_out for 1 cycle and go to DISARMED with trig_armed=0.
  - trig_disarm goes to DISARMED with no pulse.
  - trig_arm re-captures and re-evaluates per REQ-028.
REQ-030 Simultaneous trig_arm and trig_disarm: disarm SHALL win and the target is not captured.
REQ-031 Simultaneous trig_disarm and target reached: disarm SHALL win and trig_out stays 0.
REQ-032 A backward time load while ARMED SHALL NOT fire; firing occurs only when current >= target.
REQ-033 trig_out SHALL assert 2 edges after the input time first reaches or passes the target.
REQ-034 The PPS and trigger FSMs SHALL be independent; both may pulse in the same cycle.

Reset
REQ-035 On rst_n=0, asynchronously:
  - pps_out=0, pps_cnt=0, pps_ts_sec=0, trig_armed=0, trig_out=0, trig_late=0, trig_err=0.
  - Both FSMs go to IDLE/DISARMED; valid=0; the captured target is cleared.
REQ-036 Reset asserted mid-pulse or while ARMED SHALL drop pps_out and trig_armed immediately, and SHALL NOT emit trig_out after release.
REQ-037 After rst_n deasserts, the first boundary SHALL be detected no earlier than the second seconds change seen at stage 1.

Verification
REQ-038 PPS basic: pps_en=1, pps_width=100.
  - Stimulus: time steps (5,999_999_990) -> (6,0) -> +8 ns per cycle.
  - Response: pps_out high 2 edges after sec=6, low 2 edges after ns>=100; pps_cnt=1; pps_ts_sec=6.
REQ-039 Width clip: pps_width=2_000_000_000.
  - Response: pulse ends at ns>=500_000_000.
  - pps_width=0 gives a 1-cycle pulse.
  - Per REQ-024, a width producing back-to-back seconds restarts the pulse without a low cycle.
REQ-040 Trigger fire: arm at (10,0) with target (10,400).
  - Response: trig_armed=1; trig_out is one cycle, 2 edges after input reaches 400; trig_armed=0.
REQ-041 Trigger late/err:
  - Arming target (9,5) at time (10,0) gives trig_late pulse, trig_armed=0.
  - Arming trig_ns=1_000_000_000 gives trig_err.
REQ-042 Collisions:
  - arm+disarm in the same cycle leaves the FSM DISARMED.
  - disarm in the target cycle gives no trig_out.
  - A backward time load while ARMED gives no trig_out until time passes the target again.
REQ-043 Reset mid-operation: rst_n=0 during pps_out=1 and ARMED.
  - Response: all outputs 0 immediately; no pulse on the first seconds change after release; pps_cnt restarts at 0.
